// File: rtl/parity_share_pkg.sv
// Shared types and constants for the round-robin parity sharing controller.
package parity_share_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned W_DEF    = 1;
  localparam int unsigned OPCNT_W  = 16;
  localparam int unsigned MAXREQ   = 8;
  localparam int unsigned MAXIDW   = 3;

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  typedef struct packed {
    logic              found;
    logic [MAXIDW-1:0] idx;
  } rr_pick_t;

  // First requester with valid set, searching upward from ptr with wrap at nreq.
  function automatic rr_pick_t rr_pick(input logic [MAXREQ-1:0] valid,
                                       input logic [MAXIDW-1:0] ptr,
                                       input int unsigned       nreq);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 0; k < MAXREQ; k++) begin
      cand = (32'(ptr) + k) % nreq;
      if (!res.found && (k < nreq) && valid[cand[MAXIDW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[MAXIDW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/parity_share_ctrl_parity3.sv
// Shared bitwise three-input parity datapath.
module parity3 #(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);

  assign y = a ^ b ^ c;

endmodule

// File: rtl/parity_share_ctrl.sv
// Round-robin arbiter that time-shares one parity3 unit among NREQ requesters
// and returns tagged results over a valid/ready response channel.
module parity_share_ctrl
  import parity_share_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned W    = W_DEF,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*W-1:0]  req_a,
  input  logic [NREQ*W-1:0]  req_b,
  input  logic [NREQ*W-1:0]  req_c,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [W-1:0]       rsp_y,
  output logic [OPCNT_W-1:0] op_count
);

  state_t         state_q, state_d;
  rr_pick_t       pick;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic [W-1:0]   sel_a, sel_b, sel_c;
  logic [W-1:0]   op_a, op_b, op_c;
  logic [W-1:0]   par_y;
  logic           accept;
  logic           rsp_hs;

  assign pick       = rr_pick(MAXREQ'(req_valid), MAXIDW'(rr_ptr), NREQ);
  assign pick_found = pick.found;
  assign pick_idx   = IDW'(pick.idx);

  // Operand mux for the requester currently being offered the grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == IDW'(i)) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
        sel_c = req_c[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake strobes; req_ready is held low while in reset.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    rsp_hs    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found && rst_n) begin
          req_ready[pick_idx] = 1'b1;
          accept              = 1'b1;
          state_d             = CALC;
        end
      end
      CALC: state_d = HOLD;
      HOLD: begin
        if (rsp_ready) begin
          rsp_hs  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  parity3 #(.W(W)) u_parity3 (
    .a (op_a),
    .b (op_b),
    .c (op_c),
    .y (par_y)
  );

  // Operand capture, response registers, pointer and completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      op_c      <= '0;
      gnt_id    <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= '0;
      op_count  <= '0;
    end else begin
      if (accept) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        op_c   <= sel_c;
        gnt_id <= pick_idx;
      end
      if (state_q == CALC) begin
        rsp_y     <= par_y;
        rsp_id    <= gnt_id;
        rsp_valid <= 1'b1;
      end
      if (rsp_hs) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
        if (op_count != '1) op_count <= op_count + OPCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_share_ctrl.sv
// Scoreboard bench for parity_share_ctrl: tasks push expected {id, y} on accept,
// a negedge monitor pops and compares on every response handshake.
module tb_parity_share_ctrl;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 1;
  localparam int unsigned IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           y;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] req_a, req_b, req_c;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [W-1:0]    rsp_y;
  logic [15:0]     op_count;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  parity_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input logic y);
    exp_t e;
    e.id = IDW'(id);
    e.y  = y;
    exp_q.push_back(e);
  endtask

  // Grant sanity every cycle, and scoreboard compare on each response handshake.
  always @(negedge clk) begin
    exp_t e;
    chk("ready_onehot", 32'($onehot0(req_ready)), 32'(1));
    chk("ready_wo_valid", 32'(req_ready & ~req_valid), 32'(0));
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d y=%0d expected no response", rsp_id, rsp_y);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_y", 32'(rsp_y), 32'(e.y));
      end
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_y", 32'(rsp_y), 32'(0));
    chk("rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("rst_op_count", 32'(op_count), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    req_valid = '0;
    #1 rst_n = 1'b1;
  endtask

  // Offer one operand triple on requester i and wait (bounded) for its grant.
  task automatic send(input int i, input logic a, input logic b, input logic c,
                      input logic y, input bit push, output int lat);
    bit ok;
    ok  = 1'b0;
    lat = 0;
    @(posedge clk); #1;
    req_a[i]     = a;
    req_b[i]     = b;
    req_c[i]     = c;
    req_valid[i] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
      lat++;
    end
    chk("grant", 32'(ok), 32'(1));
    if (ok && push) push_exp(i, y);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", 32'(done), 32'(1));
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int        lat;
    int        acc;
    bit        ok;
    logic      par_tab[8];
    int        order[6];
    logic      fair_y[4];
    logic [2:0] v;

    par_tab = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    order   = '{0, 1, 2, 3, 0, 1};
    fair_y  = '{1'b0, 1'b0, 1'b1, 1'b0};

    do_reset();

    // Single request on requester 2: 1^0^1 = 0, grant same cycle, response 2 cycles on.
    send(2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, lat);
    chk("single_lat", 32'(lat), 32'(0));
    @(negedge clk);
    chk("single_calc_valid", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    chk("single_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("single_rsp_y", 32'(rsp_y), 32'(0));
    chk("single_rsp_id", 32'(rsp_id), 32'(2));
    @(negedge clk);
    chk("single_op_count", 32'(op_count), 32'(1));

    // All eight operand combinations on requester 0.
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      send(0, v[2], v[1], v[0], par_tab[k], 1'b1, lat);
    end
    drain();
    chk("sweep_op_count", 32'(op_count), 32'(9));

    // Round-robin with every requester valid continuously.
    do_reset();
    for (int k = 0; k < 6; k++) push_exp(order[k], fair_y[order[k]]);
    @(posedge clk); #1;
    req_a     = 4'b0110;
    req_b     = 4'b0011;
    req_c     = 4'b0001;
    req_valid = 4'hF;
    acc = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) begin
        chk("rr_order", 32'(idx_of(req_ready)), 32'(order[acc]));
        acc++;
        if (acc == 6) break;
      end
    end
    chk("rr_count", 32'(acc), 32'(6));
    @(posedge clk); #1;
    req_valid = '0;
    drain();
    chk("rr_op_count", 32'(op_count), 32'(6));

    // Backpressure: response held for 5 cycles while requester 3 waits.
    rsp_ready = 1'b0;
    send(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, lat);
    req_a[3] = 1'b1;
    req_b[3] = 1'b0;
    req_c[3] = 1'b0;
    req_valid[3] = 1'b1;
    push_exp(3, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
      chk("bp_rsp_y", 32'(rsp_y), 32'(1));
      chk("bp_rsp_id", 32'(rsp_id), 32'(1));
      chk("bp_req_ready", 32'(req_ready), 32'(0));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[3]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_next_grant", 32'(ok), 32'(1));
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    drain();
    chk("bp_op_count", 32'(op_count), 32'(8));

    // Reset during CALC: discard in-flight op, pointer restarts at 0.
    send(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, lat);
    drain();
    send(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    req_a[1] = 1'b0;
    req_b[1] = 1'b0;
    req_c[1] = 1'b1;
    req_valid = 4'b1010;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mr_rsp_y", 32'(rsp_y), 32'(0));
    chk("mr_rsp_id", 32'(rsp_id), 32'(0));
    chk("mr_op_count", 32'(op_count), 32'(0));
    chk("mr_req_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    push_exp(1, 1'b1);
    #1 rst_n = 1'b1;
    #1;
    chk("mr_first_grant", 32'(req_ready), 32'(4'b0010));
    @(posedge clk); #1;
    req_valid = '0;
    drain();
    chk("mr_op_count_after", 32'(op_count), 32'(1));

    // Counter saturation from FFFE.
    @(posedge clk); #1;
    force dut.op_count = 16'hFFFE;
    @(negedge clk);
    release dut.op_count;
    #1;
    chk("sat_preload", 32'(op_count), 32'(16'hFFFE));
    send(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, lat);
    drain();
    chk("sat_first", 32'(op_count), 32'(16'hFFFF));
    send(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, lat);
    send(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, lat);
    drain();
    chk("sat_hold", 32'(op_count), 32'(16'hFFFF));

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
